// File: rtl/spi_flash_arb_if.sv
// -----------------------------------------------------------------------------
// spi_flash_arb_if
// Bundles the requester-side SPI signals and the flash pad signals seen by
// spi_flash_arb.
//   req0/req1         requester wants the pads (held for the transaction)
//   gnt0/gnt1         requester owns the pads
//   sclkX/csX_n/sdoX  requester SPI outputs
//   sdi               pad_sdi fanned out to both requesters
//   pad_sclk/pad_cs_n/pad_sdo  to the gpio flash pins
//   pad_sdi           from the gpio flash pin
//   busy              arbiter not idle
//   owner             one-hot {owner1, owner0}, 00 when unowned
// Modports: slave = arbiter side, master = requesters plus pad side.
// -----------------------------------------------------------------------------
interface spi_flash_arb_if;
    logic       req0;
    logic       gnt0;
    logic       sclk0;
    logic       cs0_n;
    logic       sdo0;
    logic       req1;
    logic       gnt1;
    logic       sclk1;
    logic       cs1_n;
    logic       sdo1;
    logic       sdi;
    logic       pad_sclk;
    logic       pad_cs_n;
    logic       pad_sdo;
    logic       pad_sdi;
    logic       busy;
    logic [1:0] owner;

    modport slave (
        input  req0, sclk0, cs0_n, sdo0,
        input  req1, sclk1, cs1_n, sdo1,
        input  pad_sdi,
        output gnt0, gnt1, sdi,
        output pad_sclk, pad_cs_n, pad_sdo,
        output busy, owner
    );

    modport master (
        output req0, sclk0, cs0_n, sdo0,
        output req1, sclk1, cs1_n, sdo1,
        output pad_sdi,
        input  gnt0, gnt1, sdi,
        input  pad_sclk, pad_cs_n, pad_sdo,
        input  busy, owner
    );
endinterface

// File: rtl/spi_flash_arb.sv
// -----------------------------------------------------------------------------
// spi_flash_arb
// Two-master arbiter for the SPI flash pads. Requester 0 is the boot/XIP
// reader, requester 1 the APB SPI controller. Ownership changes only after
// the owner releases and CS has been held high for GUARD_CYCLES cycles plus
// one IDLE cycle. Unowned pads sit at cs_n=1, sclk=0, sdo=0.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   spi_flash_arb_if.slave (requests, grants, SPI muxing, status)
// Parameter:
//   GUARD_CYCLES  idle-CS cycles between release and re-arbitration (0..255)
// Build option:
//   SPI_FLASH_ARB_RR_EN  round-robin tie break; otherwise requester 0 wins.
// -----------------------------------------------------------------------------
module spi_flash_arb #(
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    spi_flash_arb_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1, StGuard} state_e;

    localparam bit         GuardEn   = (GUARD_CYCLES != 0);
    localparam logic [7:0] GuardLoad = (GUARD_CYCLES == 0) ? 8'd0 : 8'(GUARD_CYCLES - 1);

    state_e     r_state;
    state_e     w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       w_grant0;
    logic       w_grant1;
    logic       w_release;

`ifdef SPI_FLASH_ARB_RR_EN
    // Id of the most recently granted requester; reset to 1 so 0 wins first.
    logic       r_last;
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            StIdle: begin
                if (bus.req0 && bus.req1) begin
`ifdef SPI_FLASH_ARB_RR_EN
                    w_grant0 = r_last;
                    w_grant1 = ~r_last;
`else
                    w_grant0 = 1'b1;
`endif
                end else begin
                    w_grant0 = bus.req0;
                    w_grant1 = bus.req1;
                end
                if (w_grant0) begin
                    w_state_next = StOwn0;
                end else if (w_grant1) begin
                    w_state_next = StOwn1;
                end
            end
            StOwn0:  w_release = ~bus.req0;
            StOwn1:  w_release = ~bus.req1;
            StGuard: begin
                if (r_cnt == 8'd0) begin
                    w_state_next = StIdle;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            default: w_state_next = StIdle;
        endcase
        // With no guard interval the owner hands straight back to IDLE.
        if (w_release) begin
            if (GuardEn) begin
                w_state_next = StGuard;
                w_cnt_next   = GuardLoad;
            end else begin
                w_state_next = StIdle;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= 8'd0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_gnt0  <= (w_state_next == StOwn0);
            r_gnt1  <= (w_state_next == StOwn1);
        end
    end

`ifdef SPI_FLASH_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_grant0) begin
            r_last <= 1'b0;
        end else if (w_grant1) begin
            r_last <= 1'b1;
        end
    end
`endif

    // Pad mux keyed on the registered state: no added latency in OWNx, and
    // an asynchronous reset idles the pads immediately.
    always_comb begin
        bus.pad_sclk = 1'b0;
        bus.pad_cs_n = 1'b1;
        bus.pad_sdo  = 1'b0;
        case (r_state)
            StOwn0: begin
                bus.pad_sclk = bus.sclk0;
                bus.pad_cs_n = bus.cs0_n;
                bus.pad_sdo  = bus.sdo0;
            end
            StOwn1: begin
                bus.pad_sclk = bus.sclk1;
                bus.pad_cs_n = bus.cs1_n;
                bus.pad_sdo  = bus.sdo1;
            end
            default: ;
        endcase
    end

    assign bus.gnt0  = r_gnt0;
    assign bus.gnt1  = r_gnt1;
    assign bus.owner = {r_gnt1, r_gnt0};
    assign bus.busy  = (r_state != StIdle);
    assign bus.sdi   = bus.pad_sdi;

endmodule

// File: tb/tb_spi_flash_arb.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_arb
// Self-checking bench: per-cycle vector table on a GUARD_CYCLES=2 arbiter,
// then hand sequences for reset behaviour, tie arbitration and a
// GUARD_CYCLES=0 handoff on a second instance.
// -----------------------------------------------------------------------------
module tb_spi_flash_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    spi_flash_arb_if u_if_a ();
    spi_flash_arb_if u_if_b ();

    spi_flash_arb #(.GUARD_CYCLES(2)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (u_if_a)
    );

    spi_flash_arb #(.GUARD_CYCLES(0)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (u_if_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs for DUT A plus expected {gnt0,gnt1,owner[1:0],busy,pad_sclk,pad_cs_n,pad_sdo,sdi}.
    typedef struct {
        logic       r0, r1, s0, c0, d0, s1, c1, d1, psdi;
        logic [8:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic r0, r1, s0, c0, d0, s1, c1, d1, psdi,
                                input logic g0, g1, bz, ps, pc, pd);
        vec_t v;
        v.r0 = r0; v.r1 = r1;
        v.s0 = s0; v.c0 = c0; v.d0 = d0;
        v.s1 = s1; v.c1 = c1; v.d1 = d1;
        v.psdi = psdi;
        v.exp = {g0, g1, g1, g0, bz, ps, pc, pd, psdi};
        return v;
    endfunction

    function automatic logic [8:0] obs_a();
        return {u_if_a.gnt0, u_if_a.gnt1, u_if_a.owner, u_if_a.busy,
                u_if_a.pad_sclk, u_if_a.pad_cs_n, u_if_a.pad_sdo, u_if_a.sdi};
    endfunction

    task automatic drive_a(input vec_t v);
        u_if_a.req0  = v.r0;
        u_if_a.req1  = v.r1;
        u_if_a.sclk0 = v.s0;
        u_if_a.cs0_n = v.c0;
        u_if_a.sdo0  = v.d0;
        u_if_a.sclk1 = v.s1;
        u_if_a.cs1_n = v.c1;
        u_if_a.sdo1  = v.d1;
        u_if_a.pad_sdi = v.psdi;
    endtask

    // Grants must never overlap on either instance.
    always @(negedge clk) begin
        if (!rst) begin
            check("mutex_a", 32'(u_if_a.gnt0 & u_if_a.gnt1), 32'd0);
            check("mutex_b", 32'(u_if_b.gnt0 & u_if_b.gnt1), 32'd0);
        end
    end

    vec_t vecs[$];
    int   exp_win[4];

    initial begin
        int n;

`ifdef SPI_FLASH_ARB_RR_EN
        exp_win = '{0, 1, 0, 1};
`else
        exp_win = '{0, 0, 0, 0};
`endif

        //                r0 r1 s0 c0 d0 s1 c1 d1 sdi   g0 g1 bz ps pc pd
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1,   0, 0, 0, 0, 1, 0)); // idle
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 1, 0, 0,   1, 0, 1, 1, 0, 1)); // grant 0
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1, 1,   1, 0, 1, 0, 0, 0)); // req1 ignored
        vecs.push_back(mk(1, 1, 1, 0, 1, 1, 0, 1, 0,   1, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 1, 1, 0, 1, 1,   0, 0, 1, 0, 1, 0)); // guard, edge N
        vecs.push_back(mk(0, 1, 1, 0, 1, 1, 0, 1, 0,   0, 0, 1, 0, 1, 0)); // guard
        vecs.push_back(mk(0, 1, 1, 0, 1, 1, 0, 1, 1,   0, 0, 0, 0, 1, 0)); // idle gap
        vecs.push_back(mk(0, 1, 1, 0, 1, 1, 0, 1, 0,   0, 1, 1, 1, 0, 1)); // grant 1 after N+3
        vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 1,   0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 1, 0,   0, 1, 1, 1, 0, 1)); // mid-byte
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 1,   0, 0, 1, 0, 1, 0)); // drop, cs low
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0,   0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1,   0, 0, 0, 0, 1, 0)); // idle

        drive_a(vecs[0]);
        u_if_b.req0 = 1'b0; u_if_b.sclk0 = 1'b0; u_if_b.cs0_n = 1'b1; u_if_b.sdo0 = 1'b0;
        u_if_b.req1 = 1'b0; u_if_b.sclk1 = 1'b0; u_if_b.cs1_n = 1'b1; u_if_b.sdo1 = 1'b0;
        u_if_b.pad_sdi = 1'b0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Vector table on DUT A.
        for (int i = 0; i < vecs.size(); i++) begin
            drive_a(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), 32'(obs_a()), 32'(vecs[i].exp));
        end

        // Reset with req0 held: pads idle during reset, grant on first edge after.
        rst = 1'b1;
        u_if_a.req0 = 1'b1; u_if_a.req1 = 1'b0;
        u_if_a.sclk0 = 1'b1; u_if_a.cs0_n = 1'b0; u_if_a.sdo0 = 1'b1;
        #1;
        check("rst_pads", 32'({u_if_a.pad_sclk, u_if_a.pad_cs_n, u_if_a.pad_sdo}), 32'b010);
        check("rst_status", 32'({u_if_a.gnt0, u_if_a.gnt1, u_if_a.busy, u_if_a.owner}), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_gnt", 32'(u_if_a.gnt0), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_first_gnt", 32'({u_if_a.gnt0, u_if_a.gnt1, u_if_a.busy,
                                    u_if_a.pad_sclk, u_if_a.pad_cs_n, u_if_a.pad_sdo}),
              32'b101101);
        u_if_a.sclk0 = 1'b0; u_if_a.sdo0 = 1'b0;
        #1;
        check("own_comb_follow", 32'({u_if_a.pad_sclk, u_if_a.pad_cs_n, u_if_a.pad_sdo}),
              32'b000);

        // Asynchronous reset while owned with cs0_n low, checked before the next edge.
        rst = 1'b1;
        #1;
        check("async_rst", 32'({u_if_a.pad_cs_n, u_if_a.gnt0, u_if_a.owner, u_if_a.busy}),
              32'b10000);
        u_if_a.req0 = 1'b0; u_if_a.cs0_n = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        // Simultaneous requests over four transactions.
        for (int t = 0; t < 4; t++) begin
            u_if_a.req0 = 1'b1;
            u_if_a.req1 = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("tie_gnt%0d", t), 32'({u_if_a.gnt1, u_if_a.gnt0}),
                  (exp_win[t] == 0) ? 32'b01 : 32'b10);
            @(posedge clk);
            #1;
            u_if_a.req0 = 1'b0;
            u_if_a.req1 = 1'b0;
            for (int k = 0; k < 10 && u_if_a.busy; k++) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("tie_release%0d", t), 32'(u_if_a.busy), 32'd0);
        end

        // GUARD_CYCLES=0: owner 0 releases, requester 1 waiting.
        u_if_b.req0 = 1'b1; u_if_b.cs0_n = 1'b0;
        @(posedge clk);
        #1;
        check("b_gnt0", 32'({u_if_b.gnt0, u_if_b.gnt1}), 32'b10);
        u_if_b.req0 = 1'b0;
        u_if_b.req1 = 1'b1; u_if_b.sclk1 = 1'b1; u_if_b.cs1_n = 1'b0; u_if_b.sdo1 = 1'b1;
        @(posedge clk);
        #1;
        n = 1;
        check("b_idle_gap", 32'({u_if_b.gnt0, u_if_b.gnt1, u_if_b.busy, u_if_b.pad_cs_n}),
              32'b0001);
        while (!u_if_b.gnt1 && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b_handoff_cycles", 32'(n), 32'd2);
        check("b_own1_pads", 32'({u_if_b.pad_sclk, u_if_b.pad_cs_n, u_if_b.pad_sdo}),
              32'b101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_flash_arb.md
# spi_flash_arb

Two-master arbiter for the SPI flash pads. It sits between two SPI masters and the gpio block's flash pins (sclk, cs, sdo, sdi): requester 0 is the boot/XIP flash reader and requester 1 is the APB SPI controller. It grants the pads to one master at a time and only switches ownership across an idle-CS guard interval. While the pads are unowned or in the guard interval, it drives them to a safe idle state.

## Interface
- `GUARD_CYCLES`, default 2: cycles CS is held deasserted between one owner's release and the next arbitration. Range 0..255.
- `clk`  in  1  system clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req0`  in  1  requester 0 wants the pads; held for the whole transaction
- `gnt0`  out  1  requester 0 owns the pads (registered)
- `sclk0`, `cs0_n`, `sdo0`  in  1 each  requester 0 SPI outputs
- `req1`, `gnt1`, `sclk1`, `cs1_n`, `sdo1`: same as above, for requester 1
- `sdi`  out  1  pad `spi_sdi` fanned out to both requesters, unregistered
- `pad_sclk`  out  1  to gpio `spi_sclk`
- `pad_cs_n`  out  1  to gpio `spi_cs`
- `pad_sdo`  out  1  to gpio `spi_sdo`
- `pad_sdi`  in  1  from gpio `spi_sdi`
- `busy`  out  1  state ≠ IDLE
- `owner`  out  2  one-hot {OWN1, OWN0}; 00 when unowned

## Operation
- State machine:
  - IDLE:
    - if `req0` or `req1` is set → OWN0 or OWN1, per the Configuration policy.
    - otherwise remain in IDLE.
  - OWNx → GUARD when `reqx` is sampled low; OWNx → IDLE directly if `GUARD_CYCLES`=0.
  - GUARD: counter loads `GUARD_CYCLES`-1 on entry and decrements each cycle; at 0 → IDLE.
- Requests during GUARD are not sampled. They are evaluated in the IDLE cycle that follows.
- `gntx` = (state == OWNx), driven from a register. The other requester's `req` is ignored while one owns the pads; there is no pre-emption.
- Pad mux select is the registered state.
  - In OWNx, `pad_sclk`/`pad_cs_n`/`pad_sdo` combinationally equal `sclkx`/`csx_n`/`sdox`. There is no added latency.
  - In IDLE or GUARD: `pad_cs_n`=1, `pad_sclk`=0, `pad_sdo`=0.
- If an owner drops `req` with its `cs_n` still low, the pads return to idle the next cycle regardless. Protocol cleanliness is the master's responsibility.
- `sdi` = `pad_sdi` at all times. A non-granted master must ignore it.

## Timing
- Reset values:
  - state IDLE, `gnt0`=`gnt1`=0, `busy`=0, `owner`=00;
  - `pad_cs_n`=1, `pad_sclk`=0, `pad_sdo`=0;
  - guard counter 0; last-grant register = 1.
- Reset mid-transaction: pads go idle asynchronously on `rst` assertion.
- Grant latency: `req` sampled high in IDLE at edge N → `gnt` high after edge N. The mux switches at the same edge.
- Release: `req` sampled low at edge N → `gnt` low after N. CS stays high for exactly `GUARD_CYCLES` cycles, then one IDLE cycle, then the next grant at the following edge.
- Minimum owner-to-owner handoff is therefore `GUARD_CYCLES`+2 cycles from `req` fall to the new `gnt` rise.
- `req` dropped and re-asserted in the same owned transaction is not possible, because `req` is sampled every cycle. A one-cycle low releases the pads.

## Configuration
- `SPI_FLASH_ARB_RR_EN` defined: round-robin arbitration.
  - On simultaneous `req0` and `req1` in IDLE, grant the requester not most recently granted.
  - The last-grant register updates on every grant; its reset value of 1 makes requester 0 win first.
- Not defined: fixed priority, `req0` always wins a tie. The last-grant register is not implemented.
- Single requests are granted identically in both builds.

## Test plan
- Reset with `req0`=1 held → pads `cs_n`=1, `sclk`=0, `sdo`=0 during reset; `gnt0`=1 on the first edge after `rst` falls; the pads then follow `sclk0`/`cs0_n`/`sdo0` in the same cycle.
- `GUARD_CYCLES`=2: owner 0 releases at edge N while `req1` is high → `pad_cs_n`=1 for edges N..N+3; `gnt1` rises after edge N+3; `gnt0` and `gnt1` are never high together.
- `req0`, `req1` rise in the same cycle, repeated over 4 transactions:
  - fixed build → grants 0,0,0,0;
  - RR build → grants 0,1,0,1.
- Owner 1 drives `cs1_n`=0 and toggles `sclk1`, then drops `req1` mid-byte → `pad_cs_n`=1 and `pad_sclk`=0 from the next cycle; `busy` stays 1 through GUARD.
- `GUARD_CYCLES`=0: release then re-request by the other master → `req` fall to new `gnt` rise is 2 cycles, with one IDLE cycle and CS high.
- Assert `rst` while owned with `cs0_n`=0 → `pad_cs_n`=1 and `gnt0`=0 immediately (before the next edge); `owner`=00.
